// File: rtl/rle_video_pkg.sv
// Shared definitions for the RLE video word stream (encoder and decoder).
// Word formats: colour {len[9:0], colour[5:0]}, audio {8'hC0, sample},
// stop 16'hBFC0. Colour runs are capped so their top nibble stays below 4'hB.
package rle_video_pkg;

  localparam logic [15:0] RLE_STOP_WORD           = 16'hBFC0;
  localparam logic [7:0]  RLE_AUDIO_PREFIX        = 8'hC0;
  localparam logic [9:0]  RLE_MAX_COLOUR_RUN      = 10'h2BF;
  localparam logic [3:0]  RLE_COLOUR_NIBBLE_LIMIT = 4'hB;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_RUN,
    S_FLUSH,
    S_AUDIO,
    S_EOF
  } enc_state_t;

  function automatic logic [15:0] colour_word(input logic [9:0] len, input logic [5:0] colour);
    return {len, colour};
  endfunction

  function automatic logic [15:0] audio_word(input logic [7:0] sample);
    return {RLE_AUDIO_PREFIX, sample};
  endfunction

endpackage

// File: rtl/rle_word_reg.sv
// One-entry valid/ready output register for the RLE encoder.
// 'free' says a new word may be loaded this cycle (empty, or draining now).
// The producer only asserts 'load' while 'free' is high, so a held word is
// never overwritten.
module rle_word_reg (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        free
);

  assign free = !out_valid || out_ready;

  // Capture a new word, or retire the current one once the consumer takes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_video_encoder.sv
// Run-length encoder: merges equal consecutive pixels of a row into colour
// words, ends each frame with a stop word.
// Optional macro RLE_ENC_AUDIO_EN adds one audio word after each row.
module rle_video_encoder
  import rle_video_pkg::*;
#(
  parameter logic [9:0] MAX_RUN = RLE_MAX_COLOUR_RUN
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [5:0]  pix_colour,
  input  logic        pix_last_in_row,
  input  logic        pix_last_in_frame,
  input  logic [7:0]  audio_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        frame_done
);

  enc_state_t  state, state_n;
  logic [5:0]  cur_colour, colour_n;
  logic [9:0]  cur_len, len_n;
  logic        eof_pending, eof_n;
  logic        load;
  logic [15:0] load_data;
  logic        free;
  logic        accept;
  logic        row_end;
  logic        extend;

`ifdef RLE_ENC_AUDIO_EN
  logic [7:0]  sample_q, sample_n;
`else
  logic        unused_audio;
  assign unused_audio = ^audio_sample;
`endif

  rle_word_reg u_word_reg (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .free      (free)
  );

  // Pixels are taken only while a run can be grown and the output slot can
  // absorb a possible run word in the same cycle.
  assign pix_ready = ((state == S_EMPTY) || (state == S_RUN)) && free;
  assign accept    = pix_valid && pix_ready;
  assign row_end   = pix_last_in_row || pix_last_in_frame;
  assign extend    = (state == S_RUN) && (pix_colour == cur_colour) && (cur_len < MAX_RUN);

  // State, open run and latched row-end information.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_EMPTY;
      cur_colour  <= '0;
      cur_len     <= '0;
      eof_pending <= 1'b0;
`ifdef RLE_ENC_AUDIO_EN
      sample_q    <= '0;
`endif
    end else begin
      state       <= state_n;
      cur_colour  <= colour_n;
      cur_len     <= len_n;
      eof_pending <= eof_n;
`ifdef RLE_ENC_AUDIO_EN
      sample_q    <= sample_n;
`endif
    end
  end

  // Pulse one cycle after the stop word leaves the output register; colour
  // and audio words can never equal the stop word, so its value identifies it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && (out_data == RLE_STOP_WORD);
    end
  end

  // Next-state logic: run merging, row flush, optional audio, end of frame.
  always_comb begin
    state_n   = state;
    colour_n  = cur_colour;
    len_n     = cur_len;
    eof_n     = eof_pending;
    load      = 1'b0;
    load_data = '0;
`ifdef RLE_ENC_AUDIO_EN
    sample_n  = sample_q;
`endif
    case (state)
      S_EMPTY, S_RUN: begin
        if (accept) begin
          if (extend) begin
            len_n = cur_len + 10'd1;
          end else begin
            if (state == S_RUN) begin
              load      = 1'b1;
              load_data = colour_word(cur_len, cur_colour);
            end
            colour_n = pix_colour;
            len_n    = 10'd1;
          end
          if (row_end) begin
            state_n = S_FLUSH;
            eof_n   = pix_last_in_frame;
`ifdef RLE_ENC_AUDIO_EN
            sample_n = audio_sample;
`endif
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        if (free) begin
          load      = 1'b1;
          load_data = colour_word(cur_len, cur_colour);
          len_n     = '0;
          colour_n  = '0;
`ifdef RLE_ENC_AUDIO_EN
          state_n   = S_AUDIO;
`else
          state_n   = eof_pending ? S_EOF : S_EMPTY;
`endif
        end
      end
      S_AUDIO: begin
`ifdef RLE_ENC_AUDIO_EN
        if (free) begin
          load      = 1'b1;
          load_data = audio_word(sample_q);
          state_n   = eof_pending ? S_EOF : S_EMPTY;
        end
`else
        state_n = eof_pending ? S_EOF : S_EMPTY;
`endif
      end
      S_EOF: begin
        if (free) begin
          load      = 1'b1;
          load_data = RLE_STOP_WORD;
          eof_n     = 1'b0;
          state_n   = S_EMPTY;
        end
      end
      default: begin
        state_n = S_EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_rle_video_encoder.sv
// Self-checking bench for rle_video_encoder: directed frames plus random
// frames checked against a row/run reference model.
module tb_rle_video_encoder;

  localparam int MAXR = 703;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [5:0]  pix_colour = '0;
  logic        pix_last_in_row = 1'b0;
  logic        pix_last_in_frame = 1'b0;
  logic [7:0]  audio_sample = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        frame_done;

  rle_video_encoder dut (
    .clk               (clk),
    .rstn              (rstn),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_colour        (pix_colour),
    .pix_last_in_row   (pix_last_in_row),
    .pix_last_in_frame (pix_last_in_frame),
    .audio_sample      (audio_sample),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit [5:0]    pc[$];
  bit          plr[$];
  bit          plf[$];
  bit [7:0]    psm[$];
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          fd_count;
  int          idx;
  int          ready_mode;
  int          ready_until;
  int          ready_pct;
  int          valid_pct;
  int          stall_left;
  bit          stall_armed;
  logic [15:0] held;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void clearPixels();
    pc.delete(); plr.delete(); plf.delete(); psm.delete(); exp_q.delete();
  endfunction

  function automatic void addPixel(input bit [5:0] c, input bit lr, input bit lf, input bit [7:0] s);
    pc.push_back(c); plr.push_back(lr); plf.push_back(lf); psm.push_back(s);
  endfunction

  // Reference: split pixels into rows, rows into equal-colour runs, runs into
  // chunks of at most MAXR, then append audio/stop words at row/frame ends.
  function automatic void buildExpected();
    int start = 0;
    exp_q.delete();
    for (int i = 0; i < pc.size(); i++) begin
      if (plr[i] || plf[i]) begin
        int j = start;
        while (j <= i) begin
          int k = j;
          int len;
          while (k < i && pc[k+1] == pc[j]) k++;
          len = k - j + 1;
          while (len > 0) begin
            int c = (len > MAXR) ? MAXR : len;
            logic [9:0] c10 = c[9:0];
            exp_q.push_back({c10, pc[j]});
            len -= c;
          end
          j = k + 1;
        end
`ifdef RLE_ENC_AUDIO_EN
        exp_q.push_back({8'hC0, psm[i]});
`endif
        if (plf[i]) exp_q.push_back(16'hBFC0);
        start = i + 1;
      end
    end
  endfunction

  // One cycle: drive at the falling edge, observe handshakes 1 ns later.
  task automatic tick();
    @(negedge clk);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(99) < ready_pct);
      default: out_ready = (idx < ready_until);
    endcase
    if (stall_left > 0) out_ready = 1'b0;
    if (idx < pc.size()) begin
      pix_valid         = ($urandom_range(99) < valid_pct);
      pix_colour        = pc[idx];
      pix_last_in_row   = plr[idx];
      pix_last_in_frame = plf[idx];
      audio_sample      = psm[idx];
    end else begin
      pix_valid = 1'b0;
    end
    #1;
    if (stall_armed && out_valid) begin
      stall_armed = 1'b0;
      stall_left  = 10;
      held        = out_data;
      out_ready   = 1'b0;
      #1;
    end
    if (stall_left > 0) begin
      checkOutput("stall_pix_ready", pix_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_data", out_data, held);
      stall_left--;
    end
    if (out_valid && out_ready) got.push_back(out_data);
    if (frame_done) fd_count++;
    if (pix_valid && pix_ready) idx++;
  endtask

  task automatic applyStimulus();
    int budget = 50 * pc.size() + 200;
    int cyc = 0;
    got.delete();
    idx = 0;
    fd_count = 0;
    while ((idx < pc.size() || got.size() < exp_q.size() || stall_left > 0) && cyc < budget) begin
      tick();
      cyc++;
    end
    checkOutput("within_budget", (cyc < budget), 1);
    ready_mode = 0;
    repeat (8) tick();
  endtask

  task automatic compareStream(input string tag);
    int stops = 0;
    checkOutput({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), got[i], exp_q[i]);
    foreach (exp_q[i]) if (exp_q[i] == 16'hBFC0) stops++;
    checkOutput({tag, "_frame_done"}, fd_count, stops);
  endtask

  task automatic genFrame(input int rows);
    bit [5:0] c = 6'($urandom_range(0, 63));
    for (int r = 0; r < rows; r++) begin
      int len = ($urandom_range(0, 3) == 0) ? 30 : $urandom_range(1, 12);
      for (int p = 0; p < len; p++) begin
        bit lr = (p == len - 1);
        bit lf = lr && (r == rows - 1);
        if ($urandom_range(99) >= 65) c = 6'($urandom_range(0, 63));
        if (lf && $urandom_range(0, 1) == 1) lr = 1'b0;
        addPixel(c, lr, lf, 8'($urandom));
      end
    end
  endtask

  initial begin
    ready_mode = 0; ready_pct = 100; valid_pct = 100; ready_until = 0;
    stall_left = 0; stall_armed = 1'b0; held = '0; idx = 0; fd_count = 0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_pix_ready", pix_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("post_reset_pix_ready", pix_ready, 1);

    // Test 1: four pixels of 0x15
    clearPixels();
    for (int i = 0; i < 4; i++) addPixel(6'h15, i == 3, i == 3, 8'h00);
    exp_q = '{16'h0115, 16'hBFC0};
    applyStimulus();
    compareStream("t1");

    // Test 2: 705 pixels of 0x3F, run split at the maximum length
    clearPixels();
    for (int i = 0; i < 705; i++) addPixel(6'h3F, i == 704, i == 704, 8'h00);
    exp_q = '{16'hAFFF, 16'h00BF, 16'hBFC0};
    applyStimulus();
    compareStream("t2");
    begin
      int bad = 0;
      foreach (got[i]) if (got[i][15:12] >= 4'hB && got[i] != 16'hBFC0) bad++;
      checkOutput("t2_nibble_limit", bad, 0);
    end

    // Test 3: colour changes inside a row, then a one-pixel frame
    clearPixels();
    addPixel(6'h01, 0, 0, 8'h00);
    addPixel(6'h01, 0, 0, 8'h00);
    addPixel(6'h02, 0, 0, 8'h00);
    addPixel(6'h01, 1, 0, 8'h00);
    addPixel(6'h07, 1, 1, 8'h00);
`ifdef RLE_ENC_AUDIO_EN
    exp_q = '{16'h0081, 16'h0042, 16'h0041, 16'hC000, 16'h0047, 16'hC000, 16'hBFC0};
`else
    exp_q = '{16'h0081, 16'h0042, 16'h0041, 16'h0047, 16'hBFC0};
`endif
    applyStimulus();
    compareStream("t3");

    // Test 4: ten-cycle consumer stall mid-stream
    clearPixels();
    genFrame(3);
    buildExpected();
    stall_armed = 1'b1;
    applyStimulus();
    compareStream("t4");

    // Test 5: two rows with audio samples
    clearPixels();
    addPixel(6'h05, 0, 0, 8'h11);
    addPixel(6'h05, 1, 0, 8'h9A);
    addPixel(6'h05, 0, 0, 8'h22);
    addPixel(6'h05, 1, 1, 8'h33);
`ifdef RLE_ENC_AUDIO_EN
    exp_q = '{16'h0085, 16'hC09A, 16'h0085, 16'hC033, 16'hBFC0};
`else
    exp_q = '{16'h0085, 16'h0085, 16'hBFC0};
`endif
    applyStimulus();
    compareStream("t5");

    // Test 6: asynchronous reset with a run open and a word held
    clearPixels();
    addPixel(6'h01, 0, 0, 8'h00);
    addPixel(6'h01, 0, 0, 8'h00);
    addPixel(6'h02, 0, 0, 8'h00);
    addPixel(6'h02, 0, 0, 8'h00);
    addPixel(6'h02, 0, 0, 8'h00);
    addPixel(6'h03, 0, 0, 8'h00);
    got.delete(); idx = 0; fd_count = 0;
    ready_mode = 2; ready_until = 5;
    begin
      int cyc = 0;
      while (idx < pc.size() && cyc < 100) begin tick(); cyc++; end
      checkOutput("t6_within_budget", (cyc < 100), 1);
    end
    @(posedge clk);
    #2;
    checkOutput("t6_held_valid", out_valid, 1);
    checkOutput("t6_held_data", out_data, 16'h00C2);
    checkOutput("t6_words_before", got.size(), 1);
    if (got.size() > 0) checkOutput("t6_word0", got[0], 16'h0081);
    rstn = 1'b0;
    #1;
    checkOutput("t6_async_out_valid", out_valid, 0);
    checkOutput("t6_async_out_data", out_data, 0);
    checkOutput("t6_async_pix_ready", pix_ready, 1);
    pix_valid = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clearPixels();
    addPixel(6'h02, 1, 1, 8'h00);
`ifdef RLE_ENC_AUDIO_EN
    exp_q = '{16'h0042, 16'hC000, 16'hBFC0};
`else
    exp_q = '{16'h0042, 16'hBFC0};
`endif
    applyStimulus();
    compareStream("t6");

    // Random frames with random pixel gaps and consumer back-pressure
    for (int f = 0; f < 6; f++) begin
      clearPixels();
      genFrame($urandom_range(1, 4));
      buildExpected();
      ready_mode = 1; ready_pct = 60; valid_pct = 70;
      applyStimulus();
      compareStream($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
